presyn_spike_buffer: RTL and testbench

Elastic buffer between `axis_spike_unpack` and the `kitten_fabric_tile` presynaptic port. It absorbs spike events that the unpacker emits one cycle after sampling ready. It also decouples H2C DMA bursts from tile stalls. Events are stored in a first-word-fall-through FIFO and forwarded in arrival order. Overflow is reported through a sticky flag.

---
 rtl/kitten_spike_pkg.sv | 24 ++
 rtl/presyn_fifo_ram.sv | 28 ++
 rtl/presyn_spike_buffer.sv | 128 ++++++++++++
 tb/tb_presyn_spike_buffer.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/kitten_spike_pkg.sv
// Shared spike event types for the unpacker, presynaptic buffer and tile.
// Provides the event index width, the packed event struct and a builder.
package kitten_spike_pkg;

    localparam int SPIKE_IDX_W = 16;

    typedef struct packed {
        logic [SPIKE_IDX_W-1:0] idx;
        logic                   bit_v;
    } spike_event_t;

    localparam int SPIKE_EV_W = $bits(spike_event_t);

    function automatic spike_event_t make_event(
        input logic [SPIKE_IDX_W-1:0] idx,
        input logic                   bit_v
    );
        spike_event_t ev;
        ev.idx   = idx;
        ev.bit_v = bit_v;
        return ev;
    endfunction

endpackage

// File: rtl/presyn_fifo_ram.sv
// DEPTH x spike_event_t register array: synchronous write, async read.
// Ports: clk, we/waddr/wdata write port, raddr/rdata read port.
module presyn_fifo_ram
    import kitten_spike_pkg::*;
#(
    parameter int DEPTH = 16,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [AW-1:0]         waddr,
    input  logic [SPIKE_EV_W-1:0] wdata,
    input  logic [AW-1:0]         raddr,
    output logic [SPIKE_EV_W-1:0] rdata
);

    // Contents are never reset; stale entries are masked by occupancy.
    spike_event_t mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= spike_event_t'(wdata);
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/presyn_spike_buffer.sv
// Elastic FWFT buffer between axis_spike_unpack and the tile presyn port.
// Ports: clk, rst_n (async low); i_spike_valid/idx/bit valid-only input;
//   o_spike_ready (count <= DEPTH-2); m_presyn_valid/idx/bit/ready head
//   handshake; o_count occupancy; o_overflow sticky drop flag cleared by
//   i_clear_overflow. Option macro PRESYN_DROP_ZERO_EN drops bit-0 events.
module presyn_spike_buffer
    import kitten_spike_pkg::*;
#(
    parameter int DEPTH     = 16,
    parameter int IDX_WIDTH = SPIKE_IDX_W
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_spike_valid,
    input  logic [IDX_WIDTH-1:0]     i_spike_idx,
    input  logic                     i_spike_bit,
    output logic                     o_spike_ready,
    output logic                     m_presyn_valid,
    output logic [IDX_WIDTH-1:0]     m_presyn_idx,
    output logic                     m_presyn_bit,
    input  logic                     m_presyn_ready,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_overflow,
    input  logic                     i_clear_overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_C  = CW'(DEPTH);
    localparam logic [CW-1:0] RDY_MAX = CW'(DEPTH - 2);
    localparam logic [CW-1:0] ONE_C   = CW'(1);
    localparam logic [AW-1:0] PSTEP   = AW'(1);

    logic [AW-1:0] wp_q;
    logic [AW-1:0] rp_q;
    logic [CW-1:0] count_q;
    logic          ovf_q;

    logic          push_req;
    logic          push_ok;
    logic          pop;
    logic          drop;
    logic [CW-1:0] count_d;
    logic          ovf_d;

    spike_event_t  wr_ev;
    spike_event_t  head;
    logic [SPIKE_EV_W-1:0] rd_raw;

    // Filtered-out events are not push attempts, so they never overflow.
`ifdef PRESYN_DROP_ZERO_EN
    assign push_req = i_spike_valid & i_spike_bit;
`else
    assign push_req = i_spike_valid;
`endif

    assign m_presyn_valid = (count_q != '0);
    assign pop            = m_presyn_valid & m_presyn_ready;

    // A full buffer still accepts when the head leaves in the same cycle;
    // the write lands in the slot the pop frees (wp == rp when full).
    assign push_ok = push_req & ((count_q != FULL_C) | pop);
    assign drop    = push_req & ~push_ok;

    assign o_spike_ready = (count_q <= RDY_MAX);

    always_comb begin
        count_d = count_q;
        unique case ({push_ok, pop})
            2'b10:   count_d = count_q + ONE_C;
            2'b01:   count_d = count_q - ONE_C;
            default: count_d = count_q;
        endcase
    end

    // A drop in the same cycle as a clear keeps the flag set.
    always_comb begin
        ovf_d = ovf_q;
        if (drop) begin
            ovf_d = 1'b1;
        end else if (i_clear_overflow) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp_q    <= '0;
            rp_q    <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            if (push_ok) begin
                wp_q <= wp_q + PSTEP;
            end
            if (pop) begin
                rp_q <= rp_q + PSTEP;
            end
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    assign wr_ev = make_event(i_spike_idx, i_spike_bit);

    presyn_fifo_ram #(
        .DEPTH (DEPTH)
    ) u_ram (
        .clk   (clk),
        .we    (push_ok),
        .waddr (wp_q),
        .wdata (wr_ev),
        .raddr (rp_q),
        .rdata (rd_raw)
    );

    assign head = spike_event_t'(rd_raw);

    // Head mux is forced to zero when empty so stale RAM never leaks out.
    // With the zero filter on, only bit-1 events are ever stored, so the
    // forwarded bit is 1 whenever valid.
    assign m_presyn_idx = m_presyn_valid ? head.idx : '0;
    assign m_presyn_bit = m_presyn_valid & head.bit_v;

    assign o_count    = count_q;
    assign o_overflow = ovf_q;

endmodule

// File: tb/tb_presyn_spike_buffer.sv
// Self-checking bench for presyn_spike_buffer against a queue model.
// Build with +define+PRESYN_DROP_ZERO_EN to exercise the zero filter.
module tb_presyn_spike_buffer;

    localparam int DEPTH = 16;
    localparam int IW    = 16;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          i_spike_valid;
    logic [IW-1:0] i_spike_idx;
    logic          i_spike_bit;
    logic          o_spike_ready;
    logic          m_presyn_valid;
    logic [IW-1:0] m_presyn_idx;
    logic          m_presyn_bit;
    logic          m_presyn_ready;
    logic [CW-1:0] o_count;
    logic          o_overflow;
    logic          i_clear_overflow;

    presyn_spike_buffer #(
        .DEPTH     (DEPTH),
        .IDX_WIDTH (IW)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .i_spike_valid    (i_spike_valid),
        .i_spike_idx      (i_spike_idx),
        .i_spike_bit      (i_spike_bit),
        .o_spike_ready    (o_spike_ready),
        .m_presyn_valid   (m_presyn_valid),
        .m_presyn_idx     (m_presyn_idx),
        .m_presyn_bit     (m_presyn_bit),
        .m_presyn_ready   (m_presyn_ready),
        .o_count          (o_count),
        .o_overflow       (o_overflow),
        .i_clear_overflow (i_clear_overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [IW-1:0] idx;
        logic          b;
    } ev_t;

    int   checks = 0;
    int   errors = 0;
    ev_t  q[$];
    logic m_ovf = 1'b0;
    int   n_acc = 0;
    int   n_pop = 0;

    // One clock of stimulus; the model follows the buffer's rules directly.
    task automatic tick(input logic v, input logic [IW-1:0] idx,
                        input logic b, input logic rdy, input logic clr);
        bit pop;
        bit req;
        bit acc;
        i_spike_valid    = v;
        i_spike_idx      = idx;
        i_spike_bit      = b;
        m_presyn_ready   = rdy;
        i_clear_overflow = clr;
        pop = (q.size() != 0) && rdy;
        req = v;
`ifdef PRESYN_DROP_ZERO_EN
        req = v && b;
`endif
        acc = req && ((q.size() < DEPTH) || pop);
        @(posedge clk);
        if (pop) begin
            void'(q.pop_front());
            n_pop++;
        end
        if (acc) begin
            q.push_back('{idx, b});
            n_acc++;
        end
        if (req && !acc) m_ovf = 1'b1;
        else if (clr) m_ovf = 1'b0;
        #1;
        i_spike_valid    = 1'b0;
        i_clear_overflow = 1'b0;
        m_presyn_ready   = 1'b0;
    endtask

    task automatic test_reset;
        checks++;
        if (o_spike_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready got %b exp 1", o_spike_ready);
        end
        checks++;
        if (m_presyn_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_valid got %b exp 0", m_presyn_valid);
        end
        checks++;
        if ({m_presyn_idx, m_presyn_bit} !== '0) begin
            errors++;
            $display("FAIL reset_head got %h/%b exp 0/0",
                     m_presyn_idx, m_presyn_bit);
        end
        checks++;
        if (o_count !== '0 || o_overflow !== 1'b0) begin
            errors++;
            $display("FAIL reset_cnt_ovf got %0d/%b exp 0/0",
                     o_count, o_overflow);
        end
    endtask

    task automatic test_single;
        tick(1'b1, 16'h0005, 1'b1, 1'b0, 1'b0);
        checks++;
        if (m_presyn_valid !== 1'b1 || m_presyn_idx !== 16'h0005 ||
            m_presyn_bit !== 1'b1) begin
            errors++;
            $display("FAIL single_head got %b/%h/%b exp 1/0005/1",
                     m_presyn_valid, m_presyn_idx, m_presyn_bit);
        end
        checks++;
        if (o_count !== 5'd1) begin
            errors++;
            $display("FAIL single_count got %0d exp 1", o_count);
        end
        tick(1'b0, '0, 1'b0, 1'b1, 1'b0);
        checks++;
        if (o_count !== 5'd0 || m_presyn_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_pop got %0d/%b exp 0/0",
                     o_count, m_presyn_valid);
        end
    endtask

    // Unpacker model: emits one cycle after sampling ready high.
    task automatic test_fill;
        logic prev_rdy = 1'b1;
        logic v;
        int   k = 0;
        for (int c = 0; c < 24; c++) begin
            checks++;
            if (o_spike_ready !== (q.size() <= DEPTH - 2)) begin
                errors++;
                $display("FAIL fill_ready c=%0d got %b exp %b", c,
                         o_spike_ready, (q.size() <= DEPTH - 2));
            end
            v        = prev_rdy;
            prev_rdy = o_spike_ready;
            tick(v, 16'h0100 + 16'(k), 1'b1, 1'b0, 1'b0);
            if (v) k++;
        end
        checks++;
        if (o_count !== 5'd16 || o_overflow !== 1'b0) begin
            errors++;
            $display("FAIL fill_final got %0d/%b exp 16/0",
                     o_count, o_overflow);
        end
        for (int j = 0; j < DEPTH; j++) begin
            checks++;
            if (m_presyn_valid !== 1'b1 ||
                m_presyn_idx !== 16'h0100 + 16'(j)) begin
                errors++;
                $display("FAIL fill_order j=%0d got %b/%h exp 1/%h", j,
                         m_presyn_valid, m_presyn_idx, 16'h0100 + 16'(j));
            end
            tick(1'b0, '0, 1'b0, 1'b1, 1'b0);
        end
    endtask

    task automatic test_overflow;
        for (int j = 0; j < DEPTH; j++)
            tick(1'b1, 16'h0200 + 16'(j), 1'b1, 1'b0, 1'b0);
        tick(1'b1, 16'hDEAD, 1'b1, 1'b0, 1'b0);
        checks++;
        if (o_overflow !== 1'b1 || o_count !== 5'd16) begin
            errors++;
            $display("FAIL ovf_drop got %b/%0d exp 1/16",
                     o_overflow, o_count);
        end
        tick(1'b1, 16'hBEEF, 1'b1, 1'b1, 1'b0);
        checks++;
        if (o_count !== 5'd16 || m_presyn_idx !== 16'h0201) begin
            errors++;
            $display("FAIL ovf_pushpop got %0d/%h exp 16/0201",
                     o_count, m_presyn_idx);
        end
        tick(1'b1, 16'hF00D, 1'b1, 1'b0, 1'b1);
        checks++;
        if (o_overflow !== 1'b1) begin
            errors++;
            $display("FAIL ovf_clr_vs_drop got %b exp 1", o_overflow);
        end
        tick(1'b0, '0, 1'b0, 1'b0, 1'b1);
        checks++;
        if (o_overflow !== 1'b0) begin
            errors++;
            $display("FAIL ovf_clear got %b exp 0", o_overflow);
        end
        for (int j = 0; j < DEPTH + 2 && q.size() != 0; j++) begin
            checks++;
            if (m_presyn_idx !== q[0].idx) begin
                errors++;
                $display("FAIL ovf_drain got %h exp %h",
                         m_presyn_idx, q[0].idx);
            end
            tick(1'b0, '0, 1'b0, 1'b1, 1'b0);
        end
        checks++;
        if (q.size() != 0 || m_presyn_idx !== 16'hBEEF + 16'h0 &&
            m_presyn_valid !== 1'b0) begin
            errors++;
            $display("FAIL ovf_drained got %b exp 0", m_presyn_valid);
        end
    endtask

    task automatic test_reset_mid;
        for (int j = 0; j < 9; j++)
            tick(1'b1, 16'h0300 + 16'(j), 1'b1, 1'b0, 1'b0);
        checks++;
        if (o_count !== 5'd9) begin
            errors++;
            $display("FAIL mid_count got %0d exp 9", o_count);
        end
        #2 rst_n = 1'b0;
        q.delete();
        m_ovf = 1'b0;
        #1;
        checks++;
        if (o_count !== '0 || m_presyn_valid !== 1'b0 ||
            m_presyn_idx !== '0 || m_presyn_bit !== 1'b0 ||
            o_spike_ready !== 1'b1 || o_overflow !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset got cnt=%0d v=%b idx=%h rdy=%b exp 0/0/0/1",
                     o_count, m_presyn_valid, m_presyn_idx, o_spike_ready);
        end
        @(negedge clk) rst_n = 1'b1;
        tick(1'b1, 16'h0ABC, 1'b1, 1'b0, 1'b0);
        checks++;
        if (m_presyn_valid !== 1'b1 || m_presyn_idx !== 16'h0ABC ||
            o_count !== 5'd1) begin
            errors++;
            $display("FAIL mid_first got %b/%h/%0d exp 1/0abc/1",
                     m_presyn_valid, m_presyn_idx, o_count);
        end
        tick(1'b0, '0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_random;
        logic          v;
        logic          b;
        logic          r;
        logic          cl;
        logic [IW-1:0] ix;
        ev_t           eh;
        n_acc = 0;
        n_pop = 0;
        for (int c = 0; c < 14000; c++) begin
            eh = (q.size() != 0) ? q[0] : '{'0, 1'b0};
            checks++;
            if (o_count !== CW'(q.size()) ||
                m_presyn_valid !== (q.size() != 0) ||
                m_presyn_idx !== eh.idx || m_presyn_bit !== eh.b ||
                o_spike_ready !== (q.size() <= DEPTH - 2) ||
                o_overflow !== m_ovf) begin
                errors++;
                $display("FAIL rnd c=%0d got cnt=%0d v=%b idx=%h b=%b rdy=%b ovf=%b exp cnt=%0d idx=%h b=%b ovf=%b",
                         c, o_count, m_presyn_valid, m_presyn_idx,
                         m_presyn_bit, o_spike_ready, o_overflow,
                         q.size(), eh.idx, eh.b, m_ovf);
            end
            v  = ($urandom_range(0, 99) < (o_spike_ready ? 75 : 6));
            b  = 1'($urandom);
            ix = IW'($urandom);
            r  = ($urandom_range(0, 99) < ((c / 1000) % 2 == 1 ? 85 : 45));
            cl = ($urandom_range(0, 40) == 0);
            tick(v, ix, b, r, cl);
        end
        checks++;
        if (o_count !== CW'(n_acc - n_pop)) begin
            errors++;
            $display("FAIL rnd_balance got %0d exp %0d",
                     o_count, n_acc - n_pop);
        end
    endtask

    initial begin
        rst_n            = 1'b0;
        i_spike_valid    = 1'b0;
        i_spike_idx      = '0;
        i_spike_bit      = 1'b0;
        m_presyn_ready   = 1'b0;
        i_clear_overflow = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        test_reset;
        test_single;
        test_fill;
        test_overflow;
        test_reset_mid;
        test_random;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
